// File: rtl/servo_position_ramp.sv
// Servo command stage: debounced load key captures a clamped target position,
// and the PWM duty code slews toward it one LSB per prescaler tick.
module servo_position_ramp #(
  parameter int unsigned in_freq   = 50000000,
  parameter int unsigned step_freq = 500,
  parameter int unsigned db_cycles = 500000,
  parameter int unsigned min_pos   = 0,
  parameter int unsigned max_pos   = 255,
  parameter int unsigned home_pos  = 0
) (
  input  logic       Main_clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] target,
  input  logic       load_n,
  output logic [7:0] duty_cycle,
  output logic       busy,
  output logic       at_target
);

  localparam int unsigned POS_W    = 8;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned STEP_DIV = in_freq / step_freq;

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(db_cycles - 1);
  localparam logic [POS_W-1:0] MIN_POS   = POS_W'(min_pos);
  localparam logic [POS_W-1:0] MAX_POS   = POS_W'(max_pos);
  localparam logic [POS_W-1:0] HOME_POS  = POS_W'(home_pos);

  // Elaboration-time parameter sanity checks
  if (STEP_DIV < 2) begin : g_bad_step_div
    $error("servo_position_ramp: in_freq/step_freq must be >= 2");
  end
  if (db_cycles < 1) begin : g_bad_db_cycles
    $error("servo_position_ramp: db_cycles must be >= 1");
  end
  if ((min_pos > home_pos) || (home_pos > max_pos) || (max_pos > 255)) begin : g_bad_pos
    $error("servo_position_ramp: require min_pos <= home_pos <= max_pos <= 255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  logic [1:0]       load_sync;
  logic [POS_W-1:0] target_s1;
  logic [POS_W-1:0] target_s2;
  logic             load_s;

  logic             db_state;
  logic [CNT_W-1:0] db_cnt;
  logic             press_c;

  logic [POS_W-1:0] target_clamped;
  logic [POS_W-1:0] target_reg;

  logic [CNT_W-1:0] pre_cnt;
  logic             tick;

  state_t           state;
  state_t           state_next;
  logic [POS_W-1:0] duty_next;
  logic             busy_next;

  // Two-flop synchronisers for the asynchronous switch and key inputs
  always_ff @(posedge Main_clock or negedge reset) begin
    if (!reset) begin
      load_sync <= 2'b11;
      target_s1 <= '0;
      target_s2 <= '0;
    end else begin
      load_sync <= {load_sync[0], load_n};
      target_s1 <= target;
      target_s2 <= target_s1;
    end
  end

  assign load_s = load_sync[1];

  // Key level is accepted only after db_cycles consecutive differing samples
  always_ff @(posedge Main_clock or negedge reset) begin
    if (!reset) begin
      db_state <= 1'b1;
      db_cnt   <= '0;
    end else if (load_s == db_state) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_state <= ~db_state;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  // Press is the 1->0 transition of the debounced level, taken on the toggle edge
  assign press_c = db_state && (load_s != db_state) && (db_cnt == DB_LAST);

  always_comb begin
    target_clamped = target_s2;
    if (target_s2 < MIN_POS) begin
      target_clamped = MIN_POS;
    end else if (target_s2 > MAX_POS) begin
      target_clamped = MAX_POS;
    end
  end

  always_ff @(posedge Main_clock or negedge reset) begin
    if (!reset) begin
      target_reg <= HOME_POS;
    end else if (press_c) begin
      target_reg <= target_clamped;
    end
  end

  // Step prescaler free-runs while enabled, parked at zero otherwise
  always_ff @(posedge Main_clock or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (!enable) begin
      pre_cnt <= '0;
    end else if (pre_cnt == STEP_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + CNT_W'(1);
    end
  end

  assign tick = enable && (pre_cnt == STEP_LAST);

  // State register with the registered outputs
  always_ff @(posedge Main_clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      duty_cycle <= HOME_POS;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      duty_cycle <= duty_next;
      busy       <= busy_next;
    end
  end

  // Direction follows the registered position/target; frozen while disabled
  always_comb begin
    state_next = state;
    if (enable) begin
      if (duty_cycle < target_reg) begin
        state_next = UP;
      end else if (duty_cycle > target_reg) begin
        state_next = DOWN;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // Step uses the current state, so a capture on a tick edge takes effect next cycle
  always_comb begin
    duty_next = duty_cycle;
    busy_next = busy;
    if (enable) begin
      busy_next = (state_next != IDLE);
    end
    if (tick) begin
      case (state)
        UP:      duty_next = duty_cycle + POS_W'(1);
        DOWN:    duty_next = duty_cycle - POS_W'(1);
        default: duty_next = duty_cycle;
      endcase
    end
  end

  assign at_target = (duty_cycle == target_reg);

endmodule
